fmps_packet_scheduler: RTL

Sequencer that drives the `genPacketStrobe` input of the FMPS test-link writer. Once per fast-acquisition (FA) cycle it issues a programmable burst of single-cycle packet strobes with programmable spacing. It gates the burst on Aurora channel state and transmit backpressure, and it flags FA strobes that arrive while a burst is still in flight. It sits in the Aurora user-clock domain, between the FA timing strobe and the FMPS test-link writer.

---
 rtl/fmps_packet_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fmps_packet_scheduler.sv
// Packet strobe sequencer for the FMPS test-link writer: one burst of spaced
// single-cycle strobes per FA cycle, gated on channel state and TX backpressure.
module fmps_packet_scheduler #(
  parameter int COUNT_WIDTH   = 5,
  parameter int SPACING_WIDTH = 8
) (
  input  logic                     auroraUserClk,
  input  logic                     auroraUserResetN,
  input  logic                     enable,
  input  logic [COUNT_WIDTH-1:0]   packetCount,
  input  logic [SPACING_WIDTH-1:0] packetSpacing,
  input  logic                     auroraChannelUp,
  input  logic                     auroraFAstrobe,
  input  logic                     txHold,
  output logic                     genPacketStrobe,
  output logic [COUNT_WIDTH-1:0]   packetIndex,
  output logic                     busy,
  output logic                     overrunStrobe,
  output logic                     abortStrobe,
  output logic [15:0]              overrunCount
);

  // state  | meaning
  // IDLE   | no burst; waiting for a qualifying FA strobe
  // WAIT   | counting idle cycles / held by txHold before the next strobe
  // STROBE | genPacketStrobe is high this cycle
  typedef enum logic [1:0] {IDLE, WAIT, STROBE} state_t;

  state_t                   state, state_nxt;
  logic [COUNT_WIDTH-1:0]   cnt, cnt_nxt, idx, idx_nxt;
  logic [SPACING_WIDTH-1:0] spc, spc_nxt, delay, delay_nxt, launch_spc;
  logic                     start_ok, last, launch, overrun, abort;

  always_comb begin
    start_ok   = auroraFAstrobe && enable && auroraChannelUp && (packetCount != '0);
    last       = (state == STROBE) && (idx == cnt - COUNT_WIDTH'(1));
    state_nxt  = state;
    cnt_nxt    = cnt;
    spc_nxt    = spc;
    idx_nxt    = idx;
    delay_nxt  = delay;
    launch     = 1'b0;
    launch_spc = spc;
    overrun    = 1'b0;
    abort      = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok) begin
          cnt_nxt    = packetCount;
          spc_nxt    = packetSpacing;
          idx_nxt    = '0;
          launch     = 1'b1;
          launch_spc = packetSpacing;
        end
      end
      WAIT: begin
        overrun = auroraFAstrobe;
        if (!auroraChannelUp) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (delay != '0) begin
          delay_nxt = delay - SPACING_WIDTH'(1);
        end else if (!txHold) begin
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        overrun = auroraFAstrobe && !last;
        if (!auroraChannelUp) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (!last) begin
          idx_nxt = idx + COUNT_WIDTH'(1);
          launch  = 1'b1;
        end else if (start_ok) begin
          cnt_nxt    = packetCount;
          spc_nxt    = packetSpacing;
          idx_nxt    = '0;
          launch     = 1'b1;
          launch_spc = packetSpacing;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // delay holds the idle cycles still owed after the current one, so a
    // zero spacing skips WAIT entirely and strobes run back to back.
    if (launch) begin
      if ((launch_spc == '0) && !txHold) begin
        state_nxt = STROBE;
      end else begin
        state_nxt = WAIT;
        delay_nxt = (launch_spc == '0) ? '0 : launch_spc - SPACING_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge auroraUserClk) begin
    if (!auroraUserResetN) begin
      state           <= IDLE;
      cnt             <= '0;
      spc             <= '0;
      idx             <= '0;
      delay           <= '0;
      genPacketStrobe <= 1'b0;
      packetIndex     <= '0;
      busy            <= 1'b0;
      overrunStrobe   <= 1'b0;
      abortStrobe     <= 1'b0;
      overrunCount    <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      spc             <= spc_nxt;
      idx             <= idx_nxt;
      delay           <= delay_nxt;
      genPacketStrobe <= (state_nxt == STROBE);
      if (state_nxt == STROBE) packetIndex <= idx_nxt;
      busy            <= (state_nxt != IDLE);
      overrunStrobe   <= overrun;
      abortStrobe     <= abort;
      if (overrun && (overrunCount != 16'hFFFF)) overrunCount <= overrunCount + 16'd1;
    end
  end

endmodule
